// File: rtl/serial_mult_shift_add_hs.sv
// Shift-add serial multiplier: one multiplier bit per clock, unsigned or two's-complement.
// Optional macro ZERO_BYPASS_EN: a zero operand skips the iterations and returns 0 after two cycles.
module serial_mult_shift_add_hs #(
  parameter int WL = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              SIGNED_MODE,
  input  logic [WL-1:0]     Ain,
  input  logic [WL-1:0]     Bin,
  output logic              BUSY,
  output logic              DONE,
  output logic [2*WL-1:0]   Result
);

  localparam int CW = $clog2(WL);
  localparam logic [CW-1:0] LAST = CW'(WL - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [WL-1:0]       r_mcand;
  logic [WL-1:0]       r_hi;
  logic [WL-1:0]       r_lo;
  logic                r_signed;
  logic                r_busy;
  logic                r_done;
  logic [2*WL-1:0]     r_result;

  logic                w_last;
  logic                w_bypass;
  logic [WL:0]         w_mext;
  logic [WL:0]         w_hext;
  logic [WL:0]         w_addend;
  logic [WL:0]         w_sum;
  logic [WL-1:0]       w_hi_nxt;
  logic [WL-1:0]       w_lo_nxt;

  // The extra adder bit carries the unsigned carry-out or the signed sign, so the
  // plain right shift of {sum, lower half} is correct in both modes.
  always_comb begin
    w_last   = (r_cnt == LAST);
    w_mext   = r_signed ? {r_mcand[WL-1], r_mcand} : {1'b0, r_mcand};
    w_hext   = r_signed ? {r_hi[WL-1], r_hi} : {1'b0, r_hi};
    w_addend = r_lo[0] ? w_mext : '0;
    // Multiplier MSB carries negative weight in two's complement.
    w_sum    = (r_signed && w_last) ? (w_hext - w_addend) : (w_hext + w_addend);
    w_hi_nxt = w_sum[WL:1];
    w_lo_nxt = {w_sum[0], r_lo[WL-1:1]};
  end

`ifdef ZERO_BYPASS_EN
  assign w_bypass = (Ain == '0) || (Bin == '0);
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed operation loads zero operands and runs only the final iteration
  // with BUSY low, landing in FIN one edge later with a zero product.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_signed <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_FIN: begin
          if (START) begin
            r_mcand  <= w_bypass ? '0 : Ain;
            r_lo     <= w_bypass ? '0 : Bin;
            r_hi     <= '0;
            r_signed <= SIGNED_MODE;
            r_cnt    <= w_bypass ? LAST : '0;
            r_busy   <= !w_bypass;
            r_state  <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state  <= S_FIN;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= {w_hi_nxt, w_lo_nxt};
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign Result = r_result;

endmodule

// File: tb/tb_serial_mult_shift_add_hs.sv
// Bench for serial_mult_shift_add_hs: directed WL=4 cases, back-to-back, reset abort, WL=8 random sweep.
module tb_serial_mult_shift_add_hs;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       s4_start, s4_sm, s4_busy, s4_done;
  logic [3:0] s4_a, s4_b;
  logic [7:0] s4_res;

  logic        s8_start, s8_sm, s8_busy, s8_done;
  logic [7:0]  s8_a, s8_b;
  logic [15:0] s8_res;

  serial_mult_shift_add_hs #(.WL(4)) u_dut4 (
    .CLK(clk), .RST(rst), .START(s4_start), .SIGNED_MODE(s4_sm),
    .Ain(s4_a), .Bin(s4_b), .BUSY(s4_busy), .DONE(s4_done), .Result(s4_res)
  );

  serial_mult_shift_add_hs #(.WL(8)) u_dut8 (
    .CLK(clk), .RST(rst), .START(s8_start), .SIGNED_MODE(s8_sm),
    .Ain(s8_a), .Bin(s8_b), .BUSY(s8_busy), .DONE(s8_done), .Result(s8_res)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Exact product from plain integer arithmetic, truncated to 2*wl bits.
  function automatic logic [15:0] ref_prod(input int wl, input logic [31:0] a,
                                           input logic [31:0] b, input logic s);
    longint pa, pb;
    pa = longint'(a);
    pb = longint'(b);
    if (s && a[wl-1]) pa -= (longint'(1) << wl);
    if (s && b[wl-1]) pb -= (longint'(1) << wl);
    return 16'((pa * pb) & ((longint'(1) << (2 * wl)) - 1));
  endfunction

  function automatic bit is_byp(input logic [31:0] a, input logic [31:0] b);
`ifdef ZERO_BYPASS_EN
    return (a == 0) || (b == 0);
`else
    return (a == 0) && (b == 0) && 1'b0;
`endif
  endfunction

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s, input string tag);
    int cnt, bz, exp_lat;
    logic [15:0] e;
    exp_lat = is_byp(32'(a), 32'(b)) ? 1 : 4;
    @(negedge clk);
    s4_start = 1'b1; s4_a = a; s4_b = b; s4_sm = s;
    exp_q.push_back(ref_prod(4, 32'(a), 32'(b), s));
    @(posedge clk);
    @(negedge clk);
    s4_start = 1'b0; s4_a = 4'($urandom); s4_b = 4'($urandom); s4_sm = 1'($urandom);
    cnt = 0; bz = 0;
    while (!s4_done && cnt < 40) begin
      if (s4_busy) bz++;
      @(posedge clk); cnt++;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    check({tag, "_lat"}, cnt, exp_lat);
    check({tag, "_busy"}, bz, (exp_lat == 1) ? 0 : 4);
    check({tag, "_res"}, s4_res, e);
    @(negedge clk);
    check({tag, "_pulse"}, s4_done, 1'b0);
    check({tag, "_hold"}, s4_res, e);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
    int cnt;
    @(negedge clk);
    s8_start = 1'b1; s8_a = a; s8_b = b; s8_sm = s;
    exp_q.push_back(ref_prod(8, 32'(a), 32'(b), s));
    @(posedge clk);
    @(negedge clk);
    s8_start = 1'b0; s8_a = 8'($urandom); s8_b = 8'($urandom); s8_sm = 1'($urandom);
    cnt = 0;
    while (!s8_done && cnt < 60) begin
      @(posedge clk); cnt++;
      @(negedge clk);
    end
    check({tag, "_lat"}, cnt, is_byp(32'(a), 32'(b)) ? 1 : 8);
    check({tag, "_res"}, s8_res, exp_q.pop_front());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int seen;
    logic [3:0] pa[6];
    logic [3:0] pb[6];
    logic       ps[6];

    rst = 1'b1;
    s4_start = 1'b0; s4_sm = 1'b0; s4_a = '0; s4_b = '0;
    s8_start = 1'b0; s8_sm = 1'b0; s8_a = '0; s8_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", s4_busy, 1'b0);
    check("rst_done", s4_done, 1'b0);
    check("rst_res4", s4_res, 8'h00);
    check("rst_res8", s8_res, 16'h0000);

    op4(4'b0101, 4'b1011, 1'b0, "u5x11");
    op4(4'hF, 4'hF, 1'b0, "u15x15");
    op4(4'hD, 4'h5, 1'b1, "sm3x5");
    op4(4'h8, 4'h8, 1'b1, "sm8xm8");
    op4(4'h7, 4'hF, 1'b1, "s7xm1");
    op4(4'h0, 4'h9, 1'b0, "zero_a");
    op4(4'h6, 4'h0, 1'b1, "zero_b");

    // START held high; new pair at each FIN, scrambled operands while busy.
    for (int i = 0; i < 6; i++) begin
      pa[i] = 4'($urandom_range(1, 15));
      pb[i] = 4'($urandom_range(1, 15));
      ps[i] = 1'($urandom);
    end
    @(negedge clk);
    s4_start = 1'b1; s4_a = pa[0]; s4_b = pb[0]; s4_sm = ps[0];
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(ref_prod(4, 32'(pa[k]), 32'(pb[k]), ps[k]));
      @(posedge clk);
      @(negedge clk);
      cnt = 0;
      while (!s4_done && cnt < 40) begin
        s4_a = 4'($urandom); s4_b = 4'($urandom); s4_sm = 1'($urandom);
        @(posedge clk); cnt++;
        @(negedge clk);
      end
      check("b2b_lat", cnt, 4);
      check("b2b_res", s4_res, exp_q.pop_front());
      if (k < 5) begin
        s4_a = pa[k+1]; s4_b = pb[k+1]; s4_sm = ps[k+1];
      end else begin
        s4_start = 1'b0;
      end
    end

    // Asynchronous reset two cycles into RUN aborts the operation.
    op4(4'h9, 4'h7, 1'b0, "pre_rst");
    @(negedge clk);
    s4_start = 1'b1; s4_a = 4'h5; s4_b = 4'h3; s4_sm = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s4_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", s4_busy, 1'b0);
    check("abort_done", s4_done, 1'b0);
    check("abort_res", s4_res, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (s4_done) seen++;
    end
    check("abort_nodone", seen, 0);
    op4(4'hB, 4'h6, 1'b1, "post_rst");

    for (int m = 0; m < 2; m++) begin
      for (int n = 0; n < 1000; n++) begin
        op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'(m), m ? "rnd_s" : "rnd_u");
      end
    end
    op8(8'h80, 8'h80, 1'b1, "s8_min_min");
    op8(8'hFF, 8'hFF, 1'b0, "u8_max_max");
    op8(8'h00, 8'h9C, 1'b1, "s8_zero");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_mult_shift_add_hs.md
Name: serial_mult_shift_add_hs

Overview:
- Parametrised shift-add serial multiplier with a start/busy/done handshake and a run-time signed/unsigned mode.
- Processes one multiplier bit per clock. Result is 2*WL bits wide and is held until the next accepted operation.
- Sits in the arithmetic datapath as the area-cheap alternative to an array multiplier.
- Next generation of the single-width, unsigned, LOAD-driven shift-add multiplier.

Parameters:
- WL, 4, operand word length in bits (legal range 2..32).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request to begin a multiply; sampled on the rising edge of CLK.
- SIGNED_MODE  input  1  0 = unsigned, 1 = two's-complement; captured with the operands.
- Ain  input  WL  multiplicand; captured when START is accepted.
- Bin  input  WL  multiplier; captured when START is accepted.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  single-cycle pulse; Result is valid from this cycle onward.
- Result  output  2*WL  product; held stable until the next accepted START.

Behaviour:
- Reset (asynchronous, any state): state = IDLE, BUSY = 0, DONE = 0, Result = 0, internal count = 0, internal accumulator = 0.
- States: IDLE, RUN, FIN.
  - IDLE: START = 1 -> capture Ain, Bin and SIGNED_MODE; clear the accumulator; count = 0; go to RUN.
  - RUN: one iteration per edge. After the edge with count = WL-1, go to FIN.
  - FIN: DONE = 1 for exactly one cycle; Result = accumulator. START = 1 -> capture new operands and go to RUN (back-to-back). Otherwise go to IDLE.
- Acceptance: START is accepted only in IDLE or FIN. START while BUSY = 1 is ignored and operands are not re-captured. Ain, Bin and SIGNED_MODE are don't-care outside the accepting edge.
- BUSY = 1 in the RUN state only.
- Latency: START accepted at edge E0 -> DONE high after edge E(WL), i.e. WL+1 cycles from request to DONE. Sustained throughput is one result per WL+1 cycles.
- Iteration i (i = 0..WL-1) uses multiplier bit b_i, the current LSB of the shifting multiplier:
  - Upper WL+1-bit partial sum = upper half + (b_i ? multiplicand : 0). The adder is WL+1 bits wide to keep the carry or sign.
  - Unsigned: multiplicand is zero-extended; the carry bit shifts in on the right shift.
  - Signed: multiplicand is sign-extended. At i = WL-1 the multiplicand is subtracted instead of added (multiplier MSB weight is negative). The right shift is arithmetic.
  - Combined {partial sum, lower half} shifts right by 1; the lower half receives the multiplier bit stream.
- Result equals the exact 2*WL-bit product for all operand pairs in both modes. There is no overflow, including signed -2^(WL-1) * -2^(WL-1).
- Result is written only on the FIN transition. It never shows intermediate values.
- Reset mid-operation aborts immediately. No DONE pulse is issued and Result = 0.

Optional Feature:
- Macro ZERO_BYPASS_EN.
- Defined: if the captured Ain == 0 or Bin == 0 at the accepting edge, skip RUN and go directly to FIN.
  - DONE is asserted after E1 (2 cycles from request), Result = 0, BUSY stays 0.
  - Non-zero operands take the normal latency.
- Undefined: every operation takes the full WL iterations regardless of operand value.

Test Plan:
- WL=4, unsigned, Ain=4'b0101, Bin=4'b1011, START for 1 cycle -> BUSY high for 4 cycles; DONE pulse 1 cycle; Result = 8'h37 (55); Result holds after DONE.
- WL=4, unsigned 15*15 -> 8'hE1. Signed -3*5 (4'hD, 4'h5) -> 8'hF1. Signed -8*-8 -> 8'h40. Signed 7*-1 -> 8'hF9.
- START held high continuously with a new operand pair presented at each FIN -> back-to-back results every WL+1 cycles. START pulses asserted during BUSY do not change the in-flight result.
- RST asserted asynchronously two cycles into RUN -> BUSY, DONE and Result are 0 immediately. No DONE pulse follows. The next START produces a correct product.
- Ain=0, Bin=9: with ZERO_BYPASS_EN, DONE 2 cycles after the request and Result = 0. Without the macro, DONE after WL+1 cycles and Result = 0.
- WL=8 random sweep of 1000 pairs in each mode against a behavioural signed/unsigned product -> zero mismatches. Latency is WL+1 on every non-bypassed operation.
